// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared clear-FSM state type and address sizing helper for reg_file_param
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  // Address width for a given depth; a 1-entry file would otherwise get a zero-width address.
  function automatic int addr_w(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// rtl/regfile_clr_fsm.sv - clear sequencer: walks the register array zeroing one entry per cycle
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = addr_w(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  clr_state_t        state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;
  logic              done_q;

  // busy/done are set on the transitions so they track the state with no decode delay.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt_q == LAST_ADDR) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_busy = busy_q;
  assign clr_done = done_q;
  assign clr_we   = busy_q;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - NUM_REGS x DATA_W register file, 1 write / 2 registered reads, dirty flags, clear sequencer
// Optional REGFILE_BYPASS_EN: write-first read ports (default is read-first).
module reg_file_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = addr_w(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_ok,
  input  logic [ADDR_W-1:0]   rd0_addr,
  output logic [DATA_W-1:0]   rd0_data,
  input  logic [ADDR_W-1:0]   rd1_addr,
  output logic [DATA_W-1:0]   rd1_data,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done,
  output logic [NUM_REGS-1:0] dirty
);

  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  logic [NUM_REGS-1:0][DATA_W-1:0] mem_q;
  logic [NUM_REGS-1:0]             dirty_q;
  logic [DATA_W-1:0]               rd0_q, rd0_d;
  logic [DATA_W-1:0]               rd1_q, rd1_d;
  logic                            clr_we;
  logic [ADDR_W-1:0]               clr_addr;
  logic                            wr_in_range, rd0_in_range, rd1_in_range;

  regfile_clr_fsm #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_clr_fsm (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Non-power-of-2 depths leave address codes with no backing entry.
  assign wr_in_range  = {1'b0, wr_addr}  < NUM_REGS_W;
  assign rd0_in_range = {1'b0, rd0_addr} < NUM_REGS_W;
  assign rd1_in_range = {1'b0, rd1_addr} < NUM_REGS_W;

  assign wr_ok = wr_en & ~clr_busy & wr_in_range;

  always_comb begin
    rd0_d = '0;
    if (rd0_in_range) begin
      rd0_d = mem_q[rd0_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (wr_addr == rd0_addr)) rd0_d = wr_data;
`endif
    end
  end

  always_comb begin
    rd1_d = '0;
    if (rd1_in_range) begin
      rd1_d = mem_q[rd1_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (wr_addr == rd1_addr)) rd1_d = wr_data;
`endif
    end
  end

  // The sequencer owns the write path while busy; wr_ok is already low then.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q   <= '0;
      dirty_q <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      rd0_q <= rd0_d;
      rd1_q <= rd1_d;
      if (clr_we) begin
        mem_q[clr_addr]   <= '0;
        dirty_q[clr_addr] <= 1'b0;
      end else if (wr_ok) begin
        mem_q[wr_addr]   <= wr_data;
        dirty_q[wr_addr] <= 1'b1;
      end
    end
  end

  assign rd0_data = rd0_q;
  assign rd1_data = rd1_q;
  assign dirty    = dirty_q;

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - randomized self-checking bench for reg_file_param (8-entry and 5-entry instances)
module tb_reg_file_param;

  localparam int NR = 8;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, wr_en, clr_req;
  logic [2:0] wr_addr, rd0_addr, rd1_addr;
  logic [7:0] wr_data;
  logic       wr_ok, clr_busy, clr_done;
  logic [7:0] rd0_data, rd1_data, dirty;

  logic       wr_en_b, clr_req_b;
  logic [2:0] wr_addr_b, rd0_addr_b, rd1_addr_b;
  logic [7:0] wr_data_b;
  logic       wr_ok_b, clr_busy_b, clr_done_b;
  logic [7:0] rd0_data_b, rd1_data_b;
  logic [4:0] dirty_b;

  reg_file_param #(.DATA_W(8), .NUM_REGS(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ok(wr_ok), .rd0_addr(rd0_addr), .rd0_data(rd0_data), .rd1_addr(rd1_addr),
    .rd1_data(rd1_data), .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .dirty(dirty)
  );

  reg_file_param #(.DATA_W(8), .NUM_REGS(5)) dut_b (
    .clk(clk), .reset(reset), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .wr_ok(wr_ok_b), .rd0_addr(rd0_addr_b), .rd0_data(rd0_data_b), .rd1_addr(rd1_addr_b),
    .rd1_data(rd1_data_b), .clr_req(clr_req_b), .clr_busy(clr_busy_b), .clr_done(clr_done_b),
    .dirty(dirty_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: contents, dirty set, and clear progress (-1 idle, 0..NR-1 clearing, NR done).
  logic [7:0] m_mem [NR];
  logic [7:0] m_dirty;
  int         m_pos;
  logic [7:0] e_rd0, e_rd1;
  logic       e_wr_ok, e_busy, e_done;
  logic       obs_wr_ok, obs_wr_ok_b;

  task automatic tick();
    logic busy_m;
    busy_m  = (m_pos >= 0) && (m_pos < NR);
    e_wr_ok = wr_en && !busy_m;
    e_rd0   = (BYP && e_wr_ok && wr_addr == rd0_addr) ? wr_data : m_mem[rd0_addr];
    e_rd1   = (BYP && e_wr_ok && wr_addr == rd1_addr) ? wr_data : m_mem[rd1_addr];
    #1;
    obs_wr_ok   = wr_ok;
    obs_wr_ok_b = wr_ok_b;
    if (!reset) begin
      for (int i = 0; i < NR; i++) m_mem[i] = '0;
      m_dirty = '0;
      m_pos   = -1;
      e_rd0   = '0;
      e_rd1   = '0;
    end else begin
      if (busy_m) begin
        m_mem[m_pos]   = '0;
        m_dirty[m_pos] = 1'b0;
        m_pos++;
      end else if (m_pos == NR) begin
        m_pos = -1;
      end else if (clr_req) begin
        m_pos = 0;
      end
      if (e_wr_ok) begin
        m_mem[wr_addr]   = wr_data;
        m_dirty[wr_addr] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    e_busy = (m_pos >= 0) && (m_pos < NR);
    e_done = (m_pos == NR);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++; if (rd0_data !== 8'h00) begin errors++; $display("FAIL reset_rd0 got=%h exp=00", rd0_data); end
    checks++; if (rd1_data !== 8'h00) begin errors++; $display("FAIL reset_rd1 got=%h exp=00", rd1_data); end
    checks++; if (dirty !== 8'h00) begin errors++; $display("FAIL reset_dirty got=%b exp=00000000", dirty); end
    checks++; if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin errors++; $display("FAIL reset_clr got=%b%b exp=00", clr_busy, clr_done); end
    checks++; if (dirty_b !== 5'h00) begin errors++; $display("FAIL reset_dirty_b got=%b exp=00000", dirty_b); end
    reset = 1'b1;
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5; rd0_addr = 3'd3; rd1_addr = 3'd3;
    tick();
    checks++; if (obs_wr_ok !== 1'b1) begin errors++; $display("FAIL wr_ok_r3 got=%b exp=1", obs_wr_ok); end
    wr_en = 1'b0;
    tick();
    checks++; if (rd0_data !== 8'hA5) begin errors++; $display("FAIL wr_rd0_r3 got=%h exp=a5", rd0_data); end
    checks++; if (rd1_data !== 8'hA5) begin errors++; $display("FAIL wr_rd1_r3 got=%h exp=a5", rd1_data); end
    checks++; if (dirty !== 8'b0000_1000) begin errors++; $display("FAIL wr_dirty got=%b exp=00001000", dirty); end
  endtask

  task automatic test_same_cycle();
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h11; rd0_addr = 3'd0; rd1_addr = 3'd0;
    tick();
    wr_data = 8'h3C; rd0_addr = 3'd5;
    tick();
    checks++; if (rd0_data !== (BYP ? 8'h3C : 8'h11)) begin errors++; $display("FAIL same_cycle_rd0 got=%h exp=%h", rd0_data, BYP ? 8'h3C : 8'h11); end
    wr_en = 1'b0;
    tick();
    checks++; if (rd0_data !== 8'h3C) begin errors++; $display("FAIL same_cycle_after got=%h exp=3c", rd0_data); end
  endtask

  task automatic test_clear();
    int busy_cnt = 0;
    int done_cnt = 0;
    for (int a = 0; a < NR; a++) begin
      wr_en = 1'b1; wr_addr = 3'(a); wr_data = 8'($urandom_range(1, 255));
      tick();
    end
    wr_en = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_cnt += int'(clr_busy); done_cnt += int'(clr_done);
    for (int c = 0; c < 12; c++) begin
      wr_en = (m_pos >= 0) && (m_pos < NR);
      wr_addr = 3'($urandom); wr_data = 8'($urandom);
      rd0_addr = 3'($urandom); rd1_addr = 3'($urandom);
      tick();
      if (wr_en) begin
        checks++; if (obs_wr_ok !== 1'b0) begin errors++; $display("FAIL clr_wr_ok c=%0d got=%b exp=0", c, obs_wr_ok); end
      end
      checks++; if (rd0_data !== e_rd0) begin errors++; $display("FAIL clr_rd0 c=%0d got=%h exp=%h", c, rd0_data, e_rd0); end
      busy_cnt += int'(clr_busy); done_cnt += int'(clr_done);
    end
    wr_en = 1'b0;
    checks++; if (busy_cnt != NR) begin errors++; $display("FAIL clr_busy_cycles got=%0d exp=%0d", busy_cnt, NR); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL clr_done_pulses got=%0d exp=1", done_cnt); end
    checks++; if (dirty !== 8'h00) begin errors++; $display("FAIL clr_dirty got=%b exp=00000000", dirty); end
    for (int a = 0; a < NR; a++) begin
      rd0_addr = 3'(a); rd1_addr = 3'(NR - 1 - a);
      tick();
      checks++; if (rd0_data !== 8'h00 || rd1_data !== 8'h00) begin errors++; $display("FAIL clr_read a=%0d got=%h/%h exp=00/00", a, rd0_data, rd1_data); end
    end
  endtask

  task automatic test_reset_mid_clear();
    int busy_cnt = 0;
    int done_cnt = 0;
    for (int a = 0; a < NR; a++) begin
      wr_en = 1'b1; wr_addr = 3'(a); wr_data = 8'($urandom_range(1, 255));
      tick();
    end
    wr_en = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++; if (dirty !== 8'h00) begin errors++; $display("FAIL midrst_dirty got=%b exp=00000000", dirty); end
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", clr_busy); end
    for (int c = 0; c < 10; c++) begin
      rd0_addr = 3'($urandom); rd1_addr = 3'($urandom);
      tick();
      done_cnt += int'(clr_done);
      checks++; if (rd0_data !== 8'h00 || rd1_data !== 8'h00) begin errors++; $display("FAIL midrst_read c=%0d got=%h/%h exp=00/00", c, rd0_data, rd1_data); end
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", done_cnt); end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_cnt += int'(clr_busy); done_cnt += int'(clr_done);
    for (int c = 0; c < 12; c++) begin
      tick();
      busy_cnt += int'(clr_busy); done_cnt += int'(clr_done);
    end
    checks++; if (busy_cnt != NR) begin errors++; $display("FAIL midrst_rerun_busy got=%0d exp=%0d", busy_cnt, NR); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL midrst_rerun_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_out_of_range();
    logic [2:0] wa [4];
    logic [3:0] wok;
    wa[0] = 3'd2; wa[1] = 3'd5; wa[2] = 3'd6; wa[3] = 3'd4;
    wok = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      wr_en_b = 1'b1; wr_addr_b = wa[i]; wr_data_b = 8'h70 + 8'(i);
      tick();
      checks++; if (obs_wr_ok_b !== wok[i]) begin errors++; $display("FAIL oor_wr_ok addr=%0d got=%b exp=%b", wa[i], obs_wr_ok_b, wok[i]); end
    end
    wr_en_b = 1'b0; rd0_addr_b = 3'd7; rd1_addr_b = 3'd2;
    tick();
    checks++; if (dirty_b !== 5'b10100) begin errors++; $display("FAIL oor_dirty got=%b exp=10100", dirty_b); end
    checks++; if (rd0_data_b !== 8'h00) begin errors++; $display("FAIL oor_read7 got=%h exp=00", rd0_data_b); end
    checks++; if (rd1_data_b !== 8'h70) begin errors++; $display("FAIL oor_read2 got=%h exp=70", rd1_data_b); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      wr_en = ($urandom_range(0, 2) != 0);
      wr_addr = 3'($urandom); wr_data = 8'($urandom);
      rd0_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom);
      rd1_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom);
      clr_req = ($urandom_range(0, 49) == 0);
      tick();
      checks++; if (obs_wr_ok !== e_wr_ok) begin errors++; $display("FAIL rand_wr_ok c=%0d got=%b exp=%b", c, obs_wr_ok, e_wr_ok); end
      checks++; if (rd0_data !== e_rd0) begin errors++; $display("FAIL rand_rd0 c=%0d got=%h exp=%h", c, rd0_data, e_rd0); end
      checks++; if (rd1_data !== e_rd1) begin errors++; $display("FAIL rand_rd1 c=%0d got=%h exp=%h", c, rd1_data, e_rd1); end
      checks++; if (dirty !== m_dirty) begin errors++; $display("FAIL rand_dirty c=%0d got=%b exp=%b", c, dirty, m_dirty); end
      checks++; if (clr_busy !== e_busy || clr_done !== e_done) begin errors++; $display("FAIL rand_clr c=%0d got=%b%b exp=%b%b", c, clr_busy, clr_done, e_busy, e_done); end
    end
    clr_req = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
    wr_addr = '0; wr_data = '0; rd0_addr = '0; rd1_addr = '0;
    wr_en_b = 1'b0; clr_req_b = 1'b0;
    wr_addr_b = '0; wr_data_b = '0; rd0_addr_b = '0; rd1_addr_b = '0;
    for (int i = 0; i < NR; i++) m_mem[i] = '0;
    m_dirty = '0; m_pos = -1;
    test_reset();
    test_write_read();
    test_same_cycle();
    test_clear();
    test_reset_mid_clear();
    test_out_of_range();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
